// File: rtl/motor_seq_pkg.sv
// rtl/motor_seq_pkg.sv - shared types, widths and the saturating duty step for the motor ramp sequencer
package motor_seq_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_BRAKE = 3'd3,
    ST_DEAD  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  // One step toward goal in 9-bit arithmetic; lands exactly on goal rather than overshooting or wrapping.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] goal,
                                                    input logic [DUTY_W-1:0] step);
    logic [DUTY_W:0] wide;
    wide = '0;
    step_toward = cur;
    if (cur < goal) begin
      wide = {1'b0, cur} + {1'b0, step};
      step_toward = (wide > {1'b0, goal}) ? goal : wide[DUTY_W-1:0];
    end else if (cur > goal) begin
      wide = {1'b0, cur} - {1'b0, step};
      step_toward = (wide[DUTY_W] || (wide < {1'b0, goal})) ? goal : wide[DUTY_W-1:0];
    end
  endfunction

endpackage

// File: rtl/ramp_tick.sv
// rtl/ramp_tick.sv - prescaler counting 0..DIV-1, tick high on the terminal count, clear holds it at 0
module ramp_tick #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/motor_ramp_sequencer.sv
// rtl/motor_ramp_sequencer.sv - slew-limited duty ramp with brake, dead-time before reversal and latched estop
module motor_ramp_sequencer
  import motor_seq_pkg::*;
#(
  parameter int RAMP_DIV = 100000,
  parameter int STEP     = 1,
  parameter int DEADTIME = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_enable,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_dir,
  input  logic              estop,
  output logic [DUTY_W-1:0] duty_out,
  output logic              dir_out,
  output logic              busy,
  output logic              at_target,
  output logic              fault,
  output logic [2:0]        state_out
);

  localparam int DCW = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [DCW-1:0]    DEAD_LAST = DCW'(DEADTIME - 1);
  localparam logic [DUTY_W-1:0] STEP_V    = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] ZERO      = '0;

  state_t            state, state_n;
  logic [DUTY_W-1:0] tgt, duty_n;
  logic              dir_n;
  logic [DCW-1:0]    dead_cnt, dead_n;
  logic              tick, ramp_clear;

  ramp_tick #(.DIV(RAMP_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (ramp_clear),
    .tick  (tick)
  );

  always_comb begin
    tgt     = cmd_enable ? cmd_duty : ZERO;
    state_n = state;
    duty_n  = duty_out;
    dir_n   = dir_out;
    if (estop) begin
      state_n = ST_FAULT;
      duty_n  = ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          duty_n = ZERO;
          if (tgt != ZERO) state_n = (cmd_dir == dir_out) ? ST_RAMP : ST_DEAD;
        end
        ST_RAMP: begin
          if (cmd_dir != dir_out) begin
            state_n = ST_BRAKE;
          end else begin
            if (tick) duty_n = step_toward(duty_out, tgt, STEP_V);
            if (duty_n == tgt) state_n = (tgt == ZERO) ? ST_IDLE : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cmd_dir != dir_out) state_n = (duty_out == ZERO) ? ST_DEAD : ST_BRAKE;
          else if (tgt != duty_out) state_n = ST_RAMP;
        end
        ST_BRAKE: begin
          // Brake ignores the target; only a returning direction command cancels it.
          if (cmd_dir == dir_out && duty_out != ZERO) begin
            state_n = ST_RAMP;
          end else begin
            if (tick) duty_n = step_toward(duty_out, ZERO, STEP_V);
            if (duty_n == ZERO) state_n = ST_DEAD;
          end
        end
        ST_DEAD: begin
          duty_n = ZERO;
          if (cmd_dir == dir_out) begin
            state_n = (tgt == ZERO) ? ST_IDLE : ST_RAMP;
          end else if (dead_cnt == DEAD_LAST) begin
            dir_n   = cmd_dir;
            state_n = (tgt == ZERO) ? ST_IDLE : ST_RAMP;
          end
        end
        ST_FAULT: begin
          duty_n = ZERO;
          if (!cmd_enable) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
    dead_n     = (state == ST_DEAD && state_n == ST_DEAD) ? dead_cnt + DCW'(1) : '0;
    ramp_clear = (state_n != state) || !(state_n == ST_RAMP || state_n == ST_BRAKE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      duty_out  <= '0;
      dir_out   <= 1'b0;
      dead_cnt  <= '0;
      busy      <= 1'b0;
      at_target <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      duty_out  <= duty_n;
      dir_out   <= dir_n;
      dead_cnt  <= dead_n;
      busy      <= (state_n == ST_RAMP) || (state_n == ST_BRAKE) || (state_n == ST_DEAD);
      at_target <= (state_n == ST_HOLD) || (state_n == ST_IDLE && tgt == ZERO);
      fault     <= (state_n == ST_FAULT);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// tb/tb_motor_ramp_sequencer.sv - directed self-checking bench for motor_ramp_sequencer
module tb_motor_ramp_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_enable;
  logic [7:0] cmd_duty;
  logic       cmd_dir;
  logic       estop;
  logic [7:0] duty_out;
  logic       dir_out;
  logic       busy;
  logic       at_target;
  logic       fault;
  logic [2:0] state_out;

  int total = 0;
  int bad   = 0;

  motor_ramp_sequencer #(.RAMP_DIV(4), .STEP(16), .DEADTIME(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_enable (cmd_enable),
    .cmd_duty   (cmd_duty),
    .cmd_dir    (cmd_dir),
    .estop      (estop),
    .duty_out   (duty_out),
    .dir_out    (dir_out),
    .busy       (busy),
    .at_target  (at_target),
    .fault      (fault),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_enable = 1'b0; cmd_duty = 8'h00; cmd_dir = 1'b0; estop = 1'b0;
    cyc(3);
    total++; if (duty_out !== 8'h00) begin bad++; $display("FAIL reset_duty got=%0h exp=0", duty_out); end
    total++; if (dir_out !== 1'b0) begin bad++; $display("FAIL reset_dir got=%0b exp=0", dir_out); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b exp=0", fault); end
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    reset = 1'b0;
    cyc(1);
    total++; if (at_target !== 1'b1) begin bad++; $display("FAIL idle_at_target got=%0b exp=1", at_target); end
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL idle_state got=%0d exp=0", state_out); end
  endtask

  task automatic test_ramp_up;
    logic [7:0] exp_duty;
    cmd_enable = 1'b1; cmd_duty = 8'h40; cmd_dir = 1'b0;
    cyc(1);
    total++; if (state_out !== 3'd1) begin bad++; $display("FAIL up_enter_state got=%0d exp=1", state_out); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL up_busy got=%0b exp=1", busy); end
    cyc(3);
    total++; if (duty_out !== 8'h00) begin bad++; $display("FAIL up_no_early_step got=%0h exp=0", duty_out); end
    cyc(1);
    total++; if (duty_out !== 8'h10) begin bad++; $display("FAIL up_step1 got=%0h exp=10", duty_out); end
    exp_duty = 8'h10;
    for (int k = 2; k <= 4; k++) begin
      cyc(4);
      exp_duty = exp_duty + 8'h10;
      total++; if (duty_out !== exp_duty) begin bad++; $display("FAIL up_step%0d got=%0h exp=%0h", k, duty_out, exp_duty); end
    end
    total++; if (state_out !== 3'd2) begin bad++; $display("FAIL up_hold_state got=%0d exp=2", state_out); end
    total++; if (at_target !== 1'b1) begin bad++; $display("FAIL up_at_target got=%0b exp=1", at_target); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL up_busy_clear got=%0b exp=0", busy); end
  endtask

  task automatic test_saturate_and_down;
    logic [7:0] exp_down [5];
    exp_down = '{8'h35, 8'h25, 8'h15, 8'h05, 8'h00};
    cmd_duty = 8'h45;
    cyc(4);
    total++; if (duty_out !== 8'h40) begin bad++; $display("FAIL sat_pre got=%0h exp=40", duty_out); end
    cyc(1);
    total++; if (duty_out !== 8'h45) begin bad++; $display("FAIL sat_step got=%0h exp=45", duty_out); end
    total++; if (state_out !== 3'd2) begin bad++; $display("FAIL sat_hold got=%0d exp=2", state_out); end
    cmd_duty = 8'h00;
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      cyc(4);
      total++; if (duty_out !== exp_down[k]) begin bad++; $display("FAIL down_step%0d got=%0h exp=%0h", k, duty_out, exp_down[k]); end
    end
    total++; if (state_out !== 3'd0) begin bad++; $display("FAIL down_idle got=%0d exp=0", state_out); end
    total++; if (at_target !== 1'b1) begin bad++; $display("FAIL down_at_target got=%0b exp=1", at_target); end
  endtask

  task automatic test_reversal;
    logic [7:0] exp_brake [4];
    exp_brake = '{8'h30, 8'h20, 8'h10, 8'h00};
    cmd_duty = 8'h40;
    cyc(17);
    total++; if (state_out !== 3'd2 || duty_out !== 8'h40) begin bad++; $display("FAIL rev_setup state=%0d duty=%0h exp=2/40", state_out, duty_out); end
    cmd_dir = 1'b1;
    cyc(1);
    total++; if (state_out !== 3'd3) begin bad++; $display("FAIL rev_brake_state got=%0d exp=3", state_out); end
    for (int k = 0; k < 4; k++) begin
      cyc(4);
      total++; if (duty_out !== exp_brake[k] || dir_out !== 1'b0) begin bad++; $display("FAIL rev_brake%0d duty=%0h dir=%0b exp=%0h/0", k, duty_out, dir_out, exp_brake[k]); end
    end
    total++; if (state_out !== 3'd4) begin bad++; $display("FAIL rev_dead_enter got=%0d exp=4", state_out); end
    for (int k = 1; k < 8; k++) begin
      cyc(1);
      total++; if (state_out !== 3'd4 || dir_out !== 1'b0) begin bad++; $display("FAIL rev_dead%0d state=%0d dir=%0b exp=4/0", k, state_out, dir_out); end
    end
    cyc(1);
    total++; if (state_out !== 3'd1 || dir_out !== 1'b1) begin bad++; $display("FAIL rev_flip state=%0d dir=%0b exp=1/1", state_out, dir_out); end
    cyc(16);
    total++; if (duty_out !== 8'h40 || state_out !== 3'd2) begin bad++; $display("FAIL rev_reup duty=%0h state=%0d exp=40/2", duty_out, state_out); end
  endtask

  task automatic test_estop;
    cmd_duty = 8'h30;
    cyc(5);
    total++; if (duty_out !== 8'h30) begin bad++; $display("FAIL es_setup got=%0h exp=30", duty_out); end
    estop = 1'b1;
    cyc(1);
    estop = 1'b0;
    total++; if (duty_out !== 8'h00 || fault !== 1'b1 || state_out !== 3'd5) begin bad++; $display("FAIL es_trip duty=%0h fault=%0b state=%0d exp=0/1/5", duty_out, fault, state_out); end
    total++; if (dir_out !== 1'b1) begin bad++; $display("FAIL es_dir_kept got=%0b exp=1", dir_out); end
    cyc(3);
    total++; if (state_out !== 3'd5 || fault !== 1'b1) begin bad++; $display("FAIL es_latched state=%0d fault=%0b exp=5/1", state_out, fault); end
    cmd_enable = 1'b0;
    cyc(1);
    total++; if (state_out !== 3'd0 || fault !== 1'b0) begin bad++; $display("FAIL es_rearm state=%0d fault=%0b exp=0/0", state_out, fault); end
  endtask

  task automatic test_reset_and_abort;
    cmd_enable = 1'b1; cmd_duty = 8'h40; cmd_dir = 1'b1;
    cyc(9);
    total++; if (duty_out !== 8'h20) begin bad++; $display("FAIL mid_setup got=%0h exp=20", duty_out); end
    reset = 1'b1;
    cyc(1);
    total++; if (duty_out !== 8'h00 || dir_out !== 1'b0 || state_out !== 3'd0) begin bad++; $display("FAIL mid_reset duty=%0h dir=%0b state=%0d exp=0/0/0", duty_out, dir_out, state_out); end
    reset = 1'b0;
    cyc(1);
    total++; if (state_out !== 3'd4) begin bad++; $display("FAIL abort_dead got=%0d exp=4", state_out); end
    cyc(3);
    cmd_dir = 1'b0;
    cyc(1);
    total++; if (state_out !== 3'd1 || dir_out !== 1'b0) begin bad++; $display("FAIL abort_ramp state=%0d dir=%0b exp=1/0", state_out, dir_out); end
    cyc(4);
    total++; if (duty_out !== 8'h10 || dir_out !== 1'b0) begin bad++; $display("FAIL abort_step duty=%0h dir=%0b exp=10/0", duty_out, dir_out); end
  endtask

  initial begin
    test_reset;
    test_ramp_up;
    test_saturate_and_down;
    test_reversal;
    test_estop;
    test_reset_and_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_ramp_sequencer.md
Name: motor_ramp_sequencer

Overview:
Sequences the H-bridge motor datapath. Sits between the software-written command registers and the PWM/direction inputs of the motor peripheral. Ramps the applied duty cycle toward the commanded value at a bounded slew rate. Enforces ramp-down to zero plus a dead-time before any direction reversal, and provides a latched emergency-stop fault.

Parameters:
RAMP_DIV, 100000, clock cycles per ramp tick (>=2)
STEP, 1, duty counts added/removed per tick (1..255)
DEADTIME, 50000, clock cycles at zero duty before direction flip (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_enable  in  1  run request; 0 forces target duty to 0
cmd_duty  in  8  commanded duty (0..255)
cmd_dir  in  1  commanded direction
estop  in  1  emergency stop, level-sensitive
duty_out  out  8  applied duty to PWM generator
dir_out  out  1  applied direction to H-bridge
busy  out  1  ramp, brake or dead-time in progress
at_target  out  1  duty_out equals target, direction matches
fault  out  1  estop latched
state_out  out  3  current FSM state, for debug/AXI readback

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high. All outputs are registered.
- Reset values: duty_out=0, dir_out=0, busy=0, at_target=0, fault=0, state=IDLE. The prescaler also clears.
- Target: tgt = cmd_enable ? cmd_duty : 0. Evaluated every cycle, so mid-ramp retargeting takes effect on the next tick.
- Prescaler: counts 0..RAMP_DIV-1 and pulses tick on the terminal count. It is held at 0 in IDLE, HOLD, DEAD and FAULT. It restarts from 0 on entry to RAMP or BRAKE, so the first step lands RAMP_DIV cycles after entry.
- Step arithmetic is 9-bit:
  - Up: duty = min(duty+STEP, goal).
  - Down: duty = max(duty-STEP, goal).
  - No wrap; saturate exactly at the goal.
- States:
  - IDLE: duty 0. If tgt!=0 and cmd_dir==dir_out -> RAMP. If tgt!=0 and cmd_dir!=dir_out -> DEAD.
  - RAMP: on tick, step toward tgt. When duty==tgt -> HOLD, or -> IDLE if tgt==0. If cmd_dir!=dir_out -> BRAKE.
  - HOLD: if tgt!=duty -> RAMP. If cmd_dir!=dir_out -> BRAKE, or -> DEAD if duty==0.
  - BRAKE: on tick, step toward 0, ignoring tgt. When duty==0 -> DEAD. If cmd_dir returns equal to dir_out before duty==0 -> RAMP.
  - DEAD: duty 0; count DEADTIME cycles. At expiry, dir_out<=cmd_dir and go -> RAMP, or -> IDLE if tgt==0. If cmd_dir==dir_out mid-count, abort without flipping -> RAMP/IDLE.
  - FAULT: duty 0; fault=1. Exit to IDLE only when estop==0 and cmd_enable==0 (re-arm).
- estop=1 in any state: next edge gives duty_out=0 and state=FAULT; dir_out is unchanged. estop has priority over all other transitions.
- dir_out never changes while duty_out!=0. It changes only at DEAD expiry.
- busy=1 in RAMP, BRAKE and DEAD.
- at_target=1 in HOLD, and in IDLE with tgt==0.
- state_out encodings: IDLE=0, RAMP=1, HOLD=2, BRAKE=3, DEAD=4, FAULT=5.
- Reset mid-operation: outputs return to reset values on that edge; no ramp-down.

Decomposition:
- Package motor_seq_pkg holds:
  - the state enum (3-bit, encodings above);
  - DUTY_W=8;
  - the step/saturate function.
- Sub-module ramp_tick: parameterised prescaler with clk, reset, clear and tick ports.
- FSM, dead-time counter and duty register live in the top.

Test Plan:
Use RAMP_DIV=4, STEP=16, DEADTIME=8 for all scenarios.
1. Reset asserted 3 cycles -> duty_out=0, dir_out=0, fault=0, state_out=0, at_target=1.
2. cmd_enable=1, cmd_duty=0x40, cmd_dir=0 -> duty_out steps 0x10, 0x20, 0x30, 0x40, one step every 4 cycles. Then state HOLD, at_target=1, busy=0.
3. Raise cmd_duty to 0x45 from HOLD at 0x40 -> one tick later duty_out=0x45 (saturated, no overshoot). Then cmd_duty=0x00 -> ramps 0x35, 0x25, 0x15, 0x05, 0x00, then IDLE.
4. At HOLD 0x40 dir 0, set cmd_dir=1 -> BRAKE ramps to 0 with dir_out=0 throughout. DEAD lasts exactly 8 cycles, then dir_out=1 and ramp up to 0x40.
5. estop pulse at duty 0x30 -> next edge duty_out=0, fault=1, state FAULT. estop low with cmd_enable=1 -> stays FAULT. cmd_enable=0 -> IDLE, fault=0.
6. Reset asserted mid-RAMP at duty 0x20 -> duty_out=0 on the same edge. Toggle cmd_dir in DEAD at cycle 4 -> abort, dir_out unchanged, return to RAMP.
